// File: rtl/perf_event_counter_if.sv
// Control, event-strobe and result bundle for perf_event_counter.
// The driver uses the master modport and the counter block uses the slave modport.
interface perf_event_counter_if #(
  parameter int unsigned CW = 19
) ();
  logic          i_start;
  logic          i_halt;
  logic          i_clear;
  logic          i_ev_stall;
  logic          i_ev_arith;
  logic          i_ev_mem;
  logic          i_ev_retire;
  logic [CW-1:0] o_stall_count;
  logic [CW-1:0] o_aritmetric_count;
  logic [CW-1:0] o_memory_count;
  logic [CW-1:0] o_instruction_count;
  logic [CW-1:0] o_cycle_count;
  logic          o_running;
  logic [CW-1:0] o_cpi;
  logic          o_cpi_valid;

  modport master (
    output i_start, i_halt, i_clear, i_ev_stall, i_ev_arith, i_ev_mem, i_ev_retire,
    input  o_stall_count, o_aritmetric_count, o_memory_count, o_instruction_count,
           o_cycle_count, o_running, o_cpi, o_cpi_valid
  );

  modport slave (
    input  i_start, i_halt, i_clear, i_ev_stall, i_ev_arith, i_ev_mem, i_ev_retire,
    output o_stall_count, o_aritmetric_count, o_memory_count, o_instruction_count,
           o_cycle_count, o_running, o_cpi, o_cpi_valid
  );
endinterface

// File: rtl/perf_event_counter.sv
// Saturating pipeline event counters gated by an IDLE/RUN/FROZEN state machine.
// Optional feature macro PERF_CPI_DIV_EN adds a restoring divider that computes cycles per instruction.
module perf_event_counter #(
  parameter int unsigned CW = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  perf_event_counter_if.slave  bus
);

  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [3:0]    r_ev;
  logic [CW-1:0] r_stall_count;
  logic [CW-1:0] r_arith_count;
  logic [CW-1:0] r_mem_count;
  logic [CW-1:0] r_instr_count;
  logic [CW-1:0] r_cycle_count;
  logic          r_running;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != MAX)) ? v + CW'(1) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // clear beats halt, halt beats start; each command only acts in its own state
  always_comb begin
    w_state_nx = r_state;
    if (bus.i_clear) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.i_start) w_state_nx = S_RUN;
        S_RUN:    if (bus.i_halt)  w_state_nx = S_FROZEN;
        S_FROZEN: if (bus.i_start) w_state_nx = S_RUN;
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  // The event register always samples; the counters consume it only while RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev          <= '0;
      r_stall_count <= '0;
      r_arith_count <= '0;
      r_mem_count   <= '0;
      r_instr_count <= '0;
      r_cycle_count <= '0;
      r_running     <= 1'b0;
    end else begin
      r_running <= (w_state_nx == S_RUN);
      if (bus.i_clear) begin
        r_ev          <= '0;
        r_stall_count <= '0;
        r_arith_count <= '0;
        r_mem_count   <= '0;
        r_instr_count <= '0;
        r_cycle_count <= '0;
      end else begin
        r_ev <= {bus.i_ev_retire, bus.i_ev_mem, bus.i_ev_arith, bus.i_ev_stall};
        if (r_state == S_RUN) begin
          r_stall_count <= sat_inc(r_stall_count, r_ev[0]);
          r_arith_count <= sat_inc(r_arith_count, r_ev[1]);
          r_mem_count   <= sat_inc(r_mem_count,   r_ev[2]);
          r_instr_count <= sat_inc(r_instr_count, r_ev[3]);
          r_cycle_count <= sat_inc(r_cycle_count, 1'b1);
        end
      end
    end
  end

  assign bus.o_stall_count       = r_stall_count;
  assign bus.o_aritmetric_count  = r_arith_count;
  assign bus.o_memory_count      = r_mem_count;
  assign bus.o_instruction_count = r_instr_count;
  assign bus.o_cycle_count       = r_cycle_count;
  assign bus.o_running           = r_running;

`ifdef PERF_CPI_DIV_EN
  localparam int unsigned CNT_W = $clog2(CW);

  logic             w_freeze;
  logic             w_resume;
  logic             r_div_load;
  logic             r_div_busy;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CW-1:0]    r_div_rem;
  logic [CW-1:0]    r_div_quo;
  logic [CW-1:0]    r_div_dvs;
  logic [CW-1:0]    r_cpi;
  logic             r_cpi_valid;
  logic [CW:0]      w_sh;
  logic             w_ge;
  logic [CW-1:0]    w_rem_nx;
  logic [CW-1:0]    w_quo_nx;

  assign w_freeze = (r_state == S_RUN)    && (w_state_nx == S_FROZEN);
  assign w_resume = (r_state == S_FROZEN) && (w_state_nx == S_RUN);

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign w_sh     = {r_div_rem, r_div_quo[CW-1]};
  assign w_ge     = (w_sh >= {1'b0, r_div_dvs});
  assign w_rem_nx = w_ge ? CW'(w_sh - {1'b0, r_div_dvs}) : CW'(w_sh);
  assign w_quo_nx = {r_div_quo[CW-2:0], w_ge};

  // Operands are latched one edge after the freeze, once the final counts have settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_load  <= 1'b0;
      r_div_busy  <= 1'b0;
      r_div_cnt   <= '0;
      r_div_rem   <= '0;
      r_div_quo   <= '0;
      r_div_dvs   <= '0;
      r_cpi       <= '0;
      r_cpi_valid <= 1'b0;
    end else if (bus.i_clear) begin
      r_div_load  <= 1'b0;
      r_div_busy  <= 1'b0;
      r_div_cnt   <= '0;
      r_cpi       <= '0;
      r_cpi_valid <= 1'b0;
    end else if (w_resume) begin
      r_div_load  <= 1'b0;
      r_div_busy  <= 1'b0;
      r_cpi_valid <= 1'b0;
    end else if (w_freeze) begin
      r_div_load <= 1'b1;
    end else if (r_div_load) begin
      r_div_load <= 1'b0;
      if (r_instr_count == '0) begin
        r_cpi       <= MAX;
        r_cpi_valid <= 1'b1;
      end else begin
        r_div_busy <= 1'b1;
        r_div_cnt  <= '0;
        r_div_rem  <= '0;
        r_div_quo  <= r_cycle_count;
        r_div_dvs  <= r_instr_count;
      end
    end else if (r_div_busy) begin
      r_div_rem <= w_rem_nx;
      r_div_quo <= w_quo_nx;
      if (r_div_cnt == CNT_W'(CW - 1)) begin
        r_cpi       <= w_quo_nx;
        r_cpi_valid <= 1'b1;
        r_div_busy  <= 1'b0;
      end else begin
        r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_cpi       = r_cpi;
  assign bus.o_cpi_valid = r_cpi_valid;
`else
  assign bus.o_cpi       = '0;
  assign bus.o_cpi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_counter.sv
// Scoreboard bench for perf_event_counter: a 19-bit and a 5-bit instance share stimulus;
// a behavioural model queues expected outputs, a monitor compares after every edge.
module tb_perf_event_counter;

  localparam int unsigned CWA = 19;
  localparam int unsigned CWB = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;

  typedef struct packed {
    logic [4:0][18:0] cnt;
    logic [18:0]      cpi;
    logic             run;
    logic             cv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  perf_event_counter_if #(.CW(CWA)) bus_a ();
  perf_event_counter_if #(.CW(CWB)) bus_b ();

  perf_event_counter #(.CW(CWA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  perf_event_counter #(.CW(CWB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;
  exp_t   q0[$];
  exp_t   q1[$];

  // Model state, index 0 = 19-bit instance, 1 = 5-bit instance
  int         m_mode[2];
  bit [3:0]   m_ev[2];
  longint     m_cnt[2][5];
  longint     m_cpi[2];
  bit         m_cv[2];
  int         m_pend[2];
  longint     m_pcpi[2];
  longint     m_max[2];
  int         m_cw[2];

  task automatic cmp(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic void mzero(input int k);
    m_mode[k] = M_IDLE;
    m_ev[k]   = '0;
    for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
    m_cpi[k]  = 0;
    m_cv[k]   = 1'b0;
    m_pend[k] = 0;
    m_pcpi[k] = 0;
  endfunction

  // Spec-level next-edge behaviour of one instance
  function automatic void mstep(input int k, input bit r, input bit st, input bit ht,
                                input bit cl, input bit [3:0] ev);
    bit was_run;
    if (r || cl) begin
      mzero(k);
      return;
    end
    was_run = (m_mode[k] == M_RUN);
    if (was_run) begin
      for (int i = 0; i < 4; i++) if (m_ev[k][i]) m_cnt[k][i] = sat(m_cnt[k][i], m_max[k]);
      m_cnt[k][4] = sat(m_cnt[k][4], m_max[k]);
    end
    m_ev[k] = ev;
    if (m_pend[k] > 0) begin
      m_pend[k]--;
      if (m_pend[k] == 0) begin
        m_cpi[k] = m_pcpi[k];
        m_cv[k]  = 1'b1;
      end
    end
    if (was_run) begin
      if (ht) begin
        m_mode[k] = M_FROZEN;
`ifdef PERF_CPI_DIV_EN
        if (m_cnt[k][3] == 0) begin
          m_pend[k] = 1;
          m_pcpi[k] = m_max[k];
        end else begin
          m_pend[k] = m_cw[k] + 1;
          m_pcpi[k] = m_cnt[k][4] / m_cnt[k][3];
        end
`endif
      end
    end else if (st) begin
      m_mode[k] = M_RUN;
      m_pend[k] = 0;
      m_cv[k]   = 1'b0;
    end
  endfunction

  function automatic exp_t snap(input int k);
    exp_t e;
    for (int i = 0; i < 5; i++) e.cnt[i] = 19'(m_cnt[k][i]);
    e.cpi = 19'(m_cpi[k]);
    e.run = (m_mode[k] == M_RUN);
    e.cv  = m_cv[k];
    return e;
  endfunction

  function automatic exp_t actual(input int k);
    exp_t e;
    if (k == 0) begin
      e.cnt[0] = bus_a.o_stall_count;       e.cnt[1] = bus_a.o_aritmetric_count;
      e.cnt[2] = bus_a.o_memory_count;      e.cnt[3] = bus_a.o_instruction_count;
      e.cnt[4] = bus_a.o_cycle_count;       e.cpi    = bus_a.o_cpi;
      e.run    = bus_a.o_running;           e.cv     = bus_a.o_cpi_valid;
    end else begin
      e.cnt[0] = 19'(bus_b.o_stall_count);  e.cnt[1] = 19'(bus_b.o_aritmetric_count);
      e.cnt[2] = 19'(bus_b.o_memory_count); e.cnt[3] = 19'(bus_b.o_instruction_count);
      e.cnt[4] = 19'(bus_b.o_cycle_count);  e.cpi    = 19'(bus_b.o_cpi);
      e.run    = bus_b.o_running;           e.cv     = bus_b.o_cpi_valid;
    end
    return e;
  endfunction

  task automatic check_all(input int k, input exp_t e, input string tag);
    exp_t a;
    string nm[5] = '{"stall_count", "aritmetric_count", "memory_count", "instruction_count", "cycle_count"};
    a = actual(k);
    for (int i = 0; i < 5; i++) cmp($sformatf("%s[%0d].%s", tag, k, nm[i]), a.cnt[i], e.cnt[i]);
    cmp($sformatf("%s[%0d].running", tag, k), a.run, e.run);
    cmp($sformatf("%s[%0d].cpi", tag, k), a.cpi, e.cpi);
    cmp($sformatf("%s[%0d].cpi_valid", tag, k), a.cv, e.cv);
  endtask

  // Monitor: the DUT presents a new result after every edge
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) check_all(0, q0.pop_front(), "mon");
    if (q1.size() > 0) check_all(1, q1.pop_front(), "mon");
  end

  task automatic cyc(input bit r, input bit st, input bit ht, input bit cl, input bit [3:0] ev);
    @(negedge clk);
    rst = r;
    bus_a.i_start = st; bus_a.i_halt = ht; bus_a.i_clear = cl;
    bus_b.i_start = st; bus_b.i_halt = ht; bus_b.i_clear = cl;
    {bus_a.i_ev_retire, bus_a.i_ev_mem, bus_a.i_ev_arith, bus_a.i_ev_stall} = ev;
    {bus_b.i_ev_retire, bus_b.i_ev_mem, bus_b.i_ev_arith, bus_b.i_ev_stall} = ev;
    for (int k = 0; k < 2; k++) mstep(k, r, st, ht, cl, ev);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'b0000);
  endtask

  initial begin
    exp_t zero;
    zero  = '0;
    m_cw[0] = CWA; m_max[0] = (64'd1 << CWA) - 1;
    m_cw[1] = CWB; m_max[1] = (64'd1 << CWB) - 1;
    mzero(0); mzero(1);
    rst = 1'b1;
    bus_a.i_start = 0; bus_a.i_halt = 0; bus_a.i_clear = 0;
    bus_b.i_start = 0; bus_b.i_halt = 0; bus_b.i_clear = 0;
    {bus_a.i_ev_retire, bus_a.i_ev_mem, bus_a.i_ev_arith, bus_a.i_ev_stall} = '0;
    {bus_b.i_ev_retire, bus_b.i_ev_mem, bus_b.i_ev_arith, bus_b.i_ev_stall} = '0;
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b0000);
    #1;
    check_all(0, zero, "reset");
    idle(2);

    // Mid-count reset: counts reach 5, then rst clears everything asynchronously
    cyc(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 4'b1000);
    settle();
    cmp("pre_rst_instr", bus_a.o_instruction_count, 5);
    cyc(1, 0, 0, 0, 4'b1000);
    #1;
    check_all(0, zero, "async_rst");
    check_all(1, zero, "async_rst");
    cyc(1, 0, 0, 0, 4'b0000);
    idle(2);

    // Ten arithmetic retirements then halt
    cyc(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 4'b1010);
    cyc(0, 0, 1, 0, 4'b1111);
    idle(3);
    settle();
    cmp("t2_instr", bus_a.o_instruction_count, 10);
    cmp("t2_arith", bus_a.o_aritmetric_count, 10);
    cmp("t2_mem",   bus_a.o_memory_count, 0);
    cmp("t2_stall", bus_a.o_stall_count, 0);
    cmp("t2_running", bus_a.o_running, 0);

    // Events in IDLE are ignored; after start first count shows two edges after strobe
    cyc(0, 0, 0, 1, 4'b0000);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 4'b1111);
    settle();
    cmp("t3_idle_instr", bus_a.o_instruction_count, 0);
    cyc(0, 1, 0, 0, 4'b1111);
    settle();
    cmp("t3_start_edge_instr", bus_a.o_instruction_count, 0);
    cmp("t3_running", bus_a.o_running, 1);
    cyc(0, 0, 0, 0, 4'b1111);
    settle();
    cmp("t3_first_count", bus_a.o_instruction_count, 1);

    // Saturation: the 5-bit instance sticks at 31
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 4'b0001);
    settle();
    cmp("t4_sat_stall_b", bus_b.o_stall_count, 31);
    cmp("t4_sat_cycle_b", bus_b.o_cycle_count, 31);
    cmp("t4_stall_a", bus_a.o_stall_count, 41);

    // halt and clear together: clear wins
    cyc(0, 0, 1, 1, 4'b1111);
    settle();
    cmp("t5_running", bus_a.o_running, 0);
    cmp("t5_cycle", bus_a.o_cycle_count, 0);
    cmp("t5_instr", bus_a.o_instruction_count, 0);
    cyc(0, 1, 0, 0, 4'b0000);
    idle(6);
    cyc(0, 0, 1, 0, 4'b0000);
    settle();
    cmp("t5_run_cycles", bus_a.o_cycle_count, 7);
    cmp("t5_instr_zero", bus_a.o_instruction_count, 0);
    cmp("t5_freeze_valid", bus_a.o_cpi_valid, 0);
    cyc(0, 0, 0, 0, 4'b0000);
    settle();
`ifdef PERF_CPI_DIV_EN
    cmp("t6_div0_cpi", bus_a.o_cpi, 64'h7FFFF);
    cmp("t6_div0_valid", bus_a.o_cpi_valid, 1);
`else
    cmp("t6_nodiv_cpi", bus_a.o_cpi, 0);
    cmp("t6_nodiv_valid", bus_a.o_cpi_valid, 0);
`endif

    // 40 RUN cycles with 8 retirements: cpi=5 exactly CW+1 edges after freeze
    cyc(0, 0, 0, 1, 4'b0000);
    cyc(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 39; i++) cyc(0, 0, 0, 0, (i < 8) ? 4'b1000 : 4'b0000);
    cyc(0, 0, 1, 0, 4'b0000);
    settle();
    cmp("t6_cycle", bus_a.o_cycle_count, 40);
    cmp("t6_instr", bus_a.o_instruction_count, 8);
    for (int j = 1; j <= 20; j++) begin
      cyc(0, 0, 0, 0, 4'b0000);
      settle();
`ifdef PERF_CPI_DIV_EN
      if (j == 19) cmp("t6_valid_e19", bus_a.o_cpi_valid, 0);
      if (j == 20) begin
        cmp("t6_valid_e20", bus_a.o_cpi_valid, 1);
        cmp("t6_cpi_e20", bus_a.o_cpi, 5);
      end
`else
      if (j == 20) cmp("t6_nodiv_valid_e20", bus_a.o_cpi_valid, 0);
`endif
    end

    // Randomised traffic, including occasional asynchronous reset
    for (int i = 0; i < 2500; i++) begin
      bit r, st, ht, cl;
      r  = ($urandom_range(0, 299) == 0);
      cl = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 9) == 0);
      ht = ($urandom_range(0, 11) == 0);
      cyc(r, st, ht, cl, 4'($urandom_range(0, 15)));
    end
    idle(3);
    settle();
    cmp("queue_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
